// File: rtl/divide_seq.sv
// divide_seq: sequential restoring radix-2 divider, one quotient bit per cycle.
//
// Optional feature macro: DIVIDE_SEQ_SIGNED_EN
//   defined   -> sgn=1 at start selects a two's-complement divide (truncating
//                toward zero, remainder takes the dividend's sign) with one
//                extra FIX cycle for the sign correction.
//   undefined -> sgn is ignored; every operation is unsigned and FIX is never
//                entered.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      begin a division (sampled only in IDLE)
//   sgn        signed-mode select, sampled with start
//   dividend   numerator, sampled with start
//   divisor    denominator, sampled with start
//   busy       high whenever the FSM is not IDLE
//   done       one-cycle completion pulse; results valid from this cycle on
//   quotient   registered quotient
//   remainder  registered remainder
//   dz         divide-by-zero flag of the last completed operation
module divide_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  // Partial register: upper half = running remainder, lower half = quotient bits.
  logic [PW-1:0]    part_q, part_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_pend_q, dz_pend_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;

  // Operand magnitudes presented to the datapath at capture.
  logic [WIDTH-1:0] dvd_mag, dvs_mag;

`ifdef DIVIDE_SEQ_SIGNED_EN
  logic sgn_op_q, sgn_op_d;
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;
  logic dvd_neg, dvs_neg;

  assign dvd_neg = sgn & dividend[WIDTH-1];
  assign dvs_neg = sgn & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
`else
  logic unused_sgn;

  assign unused_sgn = sgn;
  assign dvd_mag    = dividend;
  assign dvs_mag    = divisor;
`endif

  // One restoring step. The bit shifted out of the top (carry) means the
  // shifted remainder exceeds WIDTH bits and so is certainly >= divisor; the
  // WIDTH-bit wrapped difference is then still the exact new remainder.
  logic [PW-1:0]    shifted;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] diff;
  logic             carry;
  logic             ge;

  assign shifted = {part_q[PW-2:0], 1'b0};
  assign carry   = part_q[PW-1];
  assign hi      = shifted[PW-1:WIDTH];
  assign diff    = hi - dvs_q;
  assign ge      = carry || (hi >= dvs_q);

  // Next-state and datapath logic.
  always_comb begin
    state_d   = state_q;
    part_d    = part_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    dz_pend_d = dz_pend_q;
    done_d    = 1'b0;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
`ifdef DIVIDE_SEQ_SIGNED_EN
    sgn_op_d  = sgn_op_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
`endif

    case (state_q)
      IDLE: begin
        // The IDLE cycle carrying the done pulse does not accept a new start.
        if (start && !done_q) begin
          dvs_d = dvs_mag;
`ifdef DIVIDE_SEQ_SIGNED_EN
          sgn_op_d = sgn;
          q_neg_d  = dvd_neg ^ dvs_neg;
          r_neg_d  = dvd_neg;
`endif
          if (divisor == WIDTH'(0)) begin
            // Preload the divide-by-zero result: remainder = raw dividend.
            part_d    = {dividend, {WIDTH{1'b1}}};
            dz_pend_d = 1'b1;
            state_d   = DONE;
          end else begin
            part_d    = {WIDTH'(0), dvd_mag};
            dz_pend_d = 1'b0;
            cnt_d     = CW'(WIDTH);
            state_d   = CALC;
          end
        end
      end

      CALC: begin
        part_d = ge ? {diff, shifted[WIDTH-1:1], 1'b1} : shifted;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
`ifdef DIVIDE_SEQ_SIGNED_EN
          state_d = sgn_op_q ? FIX : DONE;
`else
          state_d = DONE;
`endif
        end
      end

`ifdef DIVIDE_SEQ_SIGNED_EN
      FIX: begin
        if (q_neg_q) part_d[WIDTH-1:0]  = ~part_q[WIDTH-1:0] + WIDTH'(1);
        if (r_neg_q) part_d[PW-1:WIDTH] = ~part_q[PW-1:WIDTH] + WIDTH'(1);
        state_d = DONE;
      end
`endif

      DONE: begin
        done_d  = 1'b1;
        quot_d  = part_q[WIDTH-1:0];
        rem_d   = part_q[PW-1:WIDTH];
        dz_d    = dz_pend_q;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      part_q    <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      dz_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dz_q      <= 1'b0;
`ifdef DIVIDE_SEQ_SIGNED_EN
      sgn_op_q  <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      part_q    <= part_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      dz_pend_q <= dz_pend_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dz_q      <= dz_d;
`ifdef DIVIDE_SEQ_SIGNED_EN
      sgn_op_q  <= sgn_op_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_divide_seq.sv
// tb_divide_seq: directed-vector bench for divide_seq (WIDTH=16).
module tb_divide_seq;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sgn;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         dz;

  int n_cmp = 0;
  int n_err = 0;

  divide_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Launch one division and check latency, results and the done pulse.
  // With ctl set, extra start pulses are driven at busy cycles 3 and 10.
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic edz, input int elat,
                        input bit ctl);
    int lat;
    int extra;
    bit seen;
    @(negedge clk);
    start = 1'b1; sgn = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; sgn = ~s; dividend = 16'hA5A5; divisor = 16'h5A5A;
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      if (ctl && (lat == 3 || lat == 10)) begin
        start = 1'b1; dividend = 16'd1; divisor = 16'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, 32'(lat), 32'(elat));
    check_eq({tag, "_q"}, 32'(quotient), 32'(eq));
    check_eq({tag, "_r"}, 32'(remainder), 32'(er));
    check_eq({tag, "_dz"}, 32'(dz), 32'(edz));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 32'(done), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    if (ctl) begin
      extra = 0;
      repeat (20) begin
        @(posedge clk); #1;
        if (done || busy) extra++;
      end
      check_eq({tag, "_noqueue"}, 32'(extra), 32'd0);
      check_eq({tag, "_hold_q"}, 32'(quotient), 32'(eq));
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_q", 32'(quotient), 32'd0);
    check_eq("rst_r", 32'(remainder), 32'd0);
    check_eq("rst_dz", 32'(dz), 32'd0);
    rst = 1'b0;

    run_op("u100_7",  1'b0, 16'd100,  16'd7,    16'd14,   16'd2, 1'b0, 17, 1'b0);
    run_op("uffff_1", 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'd0, 1'b0, 17, 1'b0);
    run_op("u3_16",   1'b0, 16'h0003, 16'h0010, 16'h0000, 16'd3, 1'b0, 17, 1'b0);
    run_op("dz5",     1'b0, 16'd5,    16'd0,    16'hFFFF, 16'd5, 1'b1, 1,  1'b0);
    run_op("u9_3",    1'b0, 16'd9,    16'd3,    16'd3,    16'd0, 1'b0, 17, 1'b0);
    run_op("u_big",   1'b0, 16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFE, 1'b0, 17, 1'b0);
    run_op("u_carry", 1'b0, 16'hFFFF, 16'h8001, 16'h0001, 16'h7FFE, 1'b0, 17, 1'b0);
`ifdef DIVIDE_SEQ_SIGNED_EN
    run_op("s_m7_2",  1'b1, 16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 18, 1'b0);
    run_op("s_7_m2",  1'b1, 16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 18, 1'b0);
    run_op("s_min_m1",1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 18, 1'b0);
`else
    run_op("s_m7_2",  1'b1, 16'hFFF9, 16'd2,    16'h7FFC, 16'd1,    1'b0, 17, 1'b0);
    run_op("s_7_m2",  1'b1, 16'd7,    16'hFFFE, 16'h0000, 16'd7,    1'b0, 17, 1'b0);
    run_op("s_min_m1",1'b1, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 17, 1'b0);
`endif
    run_op("s_dz",    1'b1, 16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1, 1, 1'b0);
    run_op("ctl",     1'b0, 16'd1000, 16'd33,   16'd30,   16'd10,   1'b0, 17, 1'b1);

    // Abort with reset at CALC cycle 8; outputs hold nonzero values beforehand.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; dividend = 16'd100; divisor = 16'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_q", 32'(quotient), 32'd0);
    check_eq("abort_r", 32'(remainder), 32'd0);
    check_eq("abort_dz", 32'(dz), 32'd0);
    cnt = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy || quotient != '0) cnt++;
    end
    check_eq("abort_quiet", 32'(cnt), 32'd0);
    run_op("post_rst", 1'b0, 16'd50, 16'd6, 16'd8, 16'd2, 1'b0, 17, 1'b0);

    // Reset wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check_eq("rst_prio_busy", 32'(busy), 32'd0);
    check_eq("rst_prio_q", 32'(quotient), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
